// File: rtl/sequence_game_ctrl.sv
// Controller for a colour-sequence memory game: loads a random sequence,
// replays growing prefixes of it, then checks the player's key presses.
module sequence_game_ctrl #(
    parameter logic [15:0] SHOW_CYCLES    = 16'd25,
    parameter logic [15:0] GAP_CYCLES     = 16'd10,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd500
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [14:0] seq_in_i,
    input  logic        key_valid_i,
    input  logic [2:0]  key_colour_i,
    output logic        seq_load_o,
    output logic [3:0]  colour_sel_o,
    output logic        show_on_o,
    output logic [2:0]  level_o,
    output logic        busy_o,
    output logic        win_o,
    output logic        lose_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SNAP  = 3'd2;
    localparam logic [2:0] S_SHOW  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_INPUT = 3'd5;
    localparam logic [2:0] S_WIN   = 3'd6;
    localparam logic [2:0] S_LOSE  = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [14:0] seq_q, seq_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  level_q, level_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  cur_colour;

    always_comb begin
        cur_colour = 3'd0;
        unique case (idx_q)
            3'd1:    cur_colour = seq_q[2:0];
            3'd2:    cur_colour = seq_q[5:3];
            3'd3:    cur_colour = seq_q[8:6];
            3'd4:    cur_colour = seq_q[11:9];
            3'd5:    cur_colour = seq_q[14:12];
            default: cur_colour = 3'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_SNAP;
            S_SNAP: begin
                seq_d   = seq_in_i;
                level_d = 3'd1;
                idx_d   = 3'd1;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == SHOW_CYCLES - 16'd1) state_d = S_GAP;
            end
            S_GAP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == GAP_CYCLES - 16'd1) begin
                    if (idx_q < level_q) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SHOW;
                    end else begin
                        idx_d   = 3'd1;
                        state_d = S_INPUT;
                    end
                end
            end
            S_INPUT: begin
                cnt_d = cnt_q + 16'd1;
                // A key on the final idle cycle beats the timeout
                if (key_valid_i) begin
                    if (key_colour_i != cur_colour) begin
                        state_d = S_LOSE;
                    end else if (idx_q < level_q) begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = 16'd0;
                    end else if (level_q < 3'd5) begin
                        level_d = level_q + 3'd1;
                        idx_d   = 3'd1;
                        state_d = S_SHOW;
                    end else begin
                        state_d = S_WIN;
                    end
                end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
                    state_d = S_LOSE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = 16'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            seq_q   <= 15'd0;
            idx_q   <= 3'd0;
            level_q <= 3'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign seq_load_o   = (state_q == S_LOAD);
    assign show_on_o    = (state_q == S_SHOW);
    assign colour_sel_o = show_on_o ? {1'b0, idx_q} : 4'd0;
    assign level_o      = level_q;
    assign win_o        = (state_q == S_WIN);
    assign lose_o       = (state_q == S_LOSE);
    assign busy_o       = (state_q == S_LOAD) || (state_q == S_SNAP) ||
                          (state_q == S_SHOW) || (state_q == S_GAP)  ||
                          (state_q == S_INPUT);

endmodule

// File: tb/tb_sequence_game_ctrl.sv
// Scoreboard bench for sequence_game_ctrl: stimulus queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_sequence_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] seq_in;
    logic        key_valid;
    logic [2:0]  key_colour;
    logic        seq_load;
    logic [3:0]  colour_sel;
    logic        show_on;
    logic [2:0]  level;
    logic        busy;
    logic        win;
    logic        lose;

    int tests  = 0;
    int failed = 0;

    logic [11:0] exp_v[$];
    string       exp_n[$];
    logic [11:0] ev;
    string       en;
    logic [11:0] obs;

    localparam logic [14:0] SEQ1 = 15'b101_100_011_010_001;
    localparam logic [14:0] SEQ2 = {3'd4, 3'd1, 3'd2, 3'd6, 3'd3};

    sequence_game_ctrl #(
        .SHOW_CYCLES(16'd4),
        .GAP_CYCLES(16'd2),
        .TIMEOUT_CYCLES(16'd20)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .seq_in_i(seq_in),
        .key_valid_i(key_valid),
        .key_colour_i(key_colour),
        .seq_load_o(seq_load),
        .colour_sel_o(colour_sel),
        .show_on_o(show_on),
        .level_o(level),
        .busy_o(busy),
        .win_o(win),
        .lose_o(lose)
    );

    always #5 clk = ~clk;

    assign obs = {seq_load, colour_sel, show_on, level, busy, win, lose};

    always @(negedge clk) begin
        if (exp_v.size() != 0) begin
            ev = exp_v.pop_front();
            en = exp_n.pop_front();
            tests++;
            if (obs !== ev) begin
                failed++;
                $display("FAIL %s: got %h expected %h at %0t",
                         en, obs, ev, $time);
            end
        end
    end

    function automatic logic [11:0] ov(input logic ld,
                                       input logic [3:0] sel,
                                       input logic sh,
                                       input logic [2:0] lv,
                                       input logic b,
                                       input logic w,
                                       input logic l);
        return {ld, sel, sh, lv, b, w, l};
    endfunction

    function automatic logic [11:0] vload(input logic [2:0] lv);
        return ov(1'b1, 4'd0, 1'b0, lv, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [11:0] vwait(input logic [2:0] lv);
        return ov(1'b0, 4'd0, 1'b0, lv, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [11:0] vshow(input logic [2:0] i,
                                          input logic [2:0] lv);
        return ov(1'b0, {1'b0, i}, 1'b1, lv, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [11:0] vlose(input logic [2:0] lv);
        return ov(1'b0, 4'd0, 1'b0, lv, 1'b0, 1'b0, 1'b1);
    endfunction

    localparam logic [11:0] VIDLE = 12'd0;
    localparam logic [11:0] VWIN  = 12'b0_0000_0_101_010;

    // Queue the expectation for the current cycle, then advance one cycle
    task automatic tick(input logic [11:0] v, input string nm);
        exp_v.push_back(v);
        exp_n.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic [11:0] cur,
                              input logic [2:0] old_lv);
        start = 1'b1;
        tick(cur, "start");
        start = 1'b0;
        tick(vload(old_lv), "load");
        tick(vwait(old_lv), "snap");
    endtask

    task automatic show_round(input logic [2:0] lv, input bit noise);
        for (int i = 1; i <= int'(lv); i++) begin
            for (int c = 0; c < 4; c++) begin
                if (noise && c == 1) begin
                    key_valid  = 1'b1;
                    key_colour = 3'd7;
                end
                if (noise && c == 2) begin
                    key_valid  = 1'b1;
                    key_colour = 3'(i);
                end
                tick(vshow(3'(i), lv), "show");
                key_valid = 1'b0;
            end
            for (int c = 0; c < 2; c++) begin
                if (noise && c == 0) begin
                    key_valid  = 1'b1;
                    key_colour = 3'd1;
                end
                tick(vwait(lv), "gap");
                key_valid = 1'b0;
            end
        end
    endtask

    task automatic press(input logic [2:0] col, input logic [2:0] lv,
                         input string nm);
        key_valid  = 1'b1;
        key_colour = col;
        tick(vwait(lv), nm);
        key_valid  = 1'b0;
    endtask

    task automatic hold(input logic [11:0] v, input int n,
                        input string nm);
        for (int i = 0; i < n; i++) tick(v, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        seq_in     = SEQ1;
        key_valid  = 1'b0;
        key_colour = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick(VIDLE, "reset");
        tests++;
        if (obs !== VIDLE) begin
            failed++;
            $display("FAIL post-reset: got %h", obs);
        end

        // Game 1: full win, with key noise during round 2 replay
        start_game(VIDLE, 3'd0);
        for (int l = 1; l <= 5; l++) begin
            show_round(3'(l), l == 2);
            for (int k = 1; k <= l; k++) begin
                tick(vwait(3'(l)), "input-idle");
                press(3'(k), 3'(l), "key-ok");
            end
        end
        tick(VWIN, "win");
        key_valid  = 1'b1;
        key_colour = 3'd1;
        tick(VWIN, "win-key");
        key_valid = 1'b0;
        hold(VWIN, 2, "win-hold");
        tests++;
        if (obs !== VWIN) begin
            failed++;
            $display("FAIL win-direct: got %h", obs);
        end

        // Game 2: wrong key at level 2; seq_in changes after snapshot
        seq_in = SEQ2;
        start_game(VWIN, 3'd5);
        seq_in = 15'h7fff;
        show_round(3'd1, 1'b0);
        tick(vwait(3'd1), "input-idle");
        press(3'd3, 3'd1, "key-snap");
        show_round(3'd2, 1'b0);
        press(3'd7, 3'd2, "key-wrong");
        hold(vlose(3'd2), 3, "lose-hold");
        tests++;
        if (obs !== vlose(3'd2)) begin
            failed++;
            $display("FAIL lose-direct: got %h", obs);
        end

        // Game 3: key on the 20th idle cycle, then a true timeout
        seq_in = SEQ1;
        start_game(vlose(3'd2), 3'd2);
        show_round(3'd1, 1'b0);
        hold(vwait(3'd1), 19, "to-wait");
        press(3'd1, 3'd1, "key-at-20");
        show_round(3'd2, 1'b0);
        hold(vwait(3'd2), 2, "input-idle");
        press(3'd1, 3'd2, "key-ok");
        hold(vwait(3'd2), 20, "to-idle");
        hold(vlose(3'd2), 2, "timeout-lose");

        // Game 4: reset in the middle of a level 3 replay
        start_game(vlose(3'd2), 3'd2);
        show_round(3'd1, 1'b0);
        press(3'd1, 3'd1, "key-ok");
        show_round(3'd2, 1'b0);
        press(3'd1, 3'd2, "key-ok");
        press(3'd2, 3'd2, "key-ok");
        hold(vshow(3'd1, 3'd3), 2, "show-l3");
        rst        = 1'b1;
        start      = 1'b1;
        key_valid  = 1'b1;
        key_colour = 3'd1;
        tick(vshow(3'd1, 3'd3), "pre-rst");
        rst       = 1'b0;
        start     = 1'b0;
        key_valid = 1'b0;
        tick(VIDLE, "rst-mid-show");
        key_valid = 1'b1;
        tick(VIDLE, "idle-key");
        key_valid = 1'b0;
        hold(VIDLE, 2, "idle-hold");
        tests++;
        if (obs !== VIDLE) begin
            failed++;
            $display("FAIL idle-direct: got %h", obs);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
